// File: rtl/fpu_req_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the FPU requester.
// ST_FLUSH exists only when FPU_REQ_TIMEOUT_EN is defined.
package fpu_req_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SQRT = 3'd4;

  // Flag vector is XZOUI, X in the MSB.
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned FLAG_X = 4;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_O = 2;
  localparam int unsigned FLAG_U = 1;
  localparam int unsigned FLAG_I = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
`ifdef FPU_REQ_TIMEOUT_EN
    ST_FLUSH = 3'd4,
`endif
    ST_RESP  = 3'd3
  } state_e;

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  op_code;
    logic        round_mode;
    logic        mode_fp;
  } oper_t;

  // A clear in the capture cycle drops the old flags but keeps the new ones.
  function automatic logic [FLAG_W-1:0] merge_flags(input logic clr,
                                                    input logic [FLAG_W-1:0] old_flags,
                                                    input logic [FLAG_W-1:0] new_flags);
    return (clr ? '0 : old_flags) | new_flags;
  endfunction

endpackage

// File: rtl/fpu_req_watchdog.sv
// Counts consecutive enabled cycles; expired is high on the LIMIT-th one.
// Combinational expired output, counter clears whenever en drops.
module fpu_req_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired = en && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fpu_requester.sv
// One-in-flight FPU requester: 1 cycle accept->alu_start, 1 cycle alu_valid_out->rsp_valid; rsp_* held until rsp_ready.
// FPU_REQ_TIMEOUT_EN adds a WAIT watchdog that aborts into FLUSH and returns a timeout response.
module fpu_requester
  import fpu_req_pkg::*;
#(
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_op_a,
  input  logic [31:0]       cmd_op_b,
  input  logic [2:0]        cmd_op_code,
  input  logic              cmd_round_mode,
  input  logic              cmd_mode_fp,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              alu_start,
  output logic [31:0]       alu_op_a,
  output logic [31:0]       alu_op_b,
  output logic [2:0]        alu_op_code,
  output logic              alu_round_mode,
  output logic              alu_mode_fp,
  output logic              alu_ready_in,
  input  logic              alu_ready_out,
  input  logic              alu_valid_out,
  input  logic [31:0]       alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_timeout,
  output logic [FLAG_W-1:0] sticky_flags,
  input  logic              sticky_clr
);

  state_e            state_q;
  oper_t             oper_q;
  logic [TAG_W-1:0]  tag_q;
  logic [31:0]       rsp_result_q;
  logic [FLAG_W-1:0] rsp_flags_q;
  logic [FLAG_W-1:0] sticky_q, sticky_d;
  logic              capture;

  assign capture = (state_q == ST_WAIT) && alu_valid_out;

`ifdef FPU_REQ_TIMEOUT_EN
  logic wd_expired;
  logic rsp_timeout_q;

  fpu_req_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == ST_WAIT),
    .expired (wd_expired)
  );

  assign rsp_timeout  = rsp_timeout_q;
  assign alu_ready_in = (state_q == ST_WAIT) || (state_q == ST_FLUSH);
`else
  // TIMEOUT_CYCLES only matters with the watchdog built in.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog_cfg
  end

  assign rsp_timeout  = 1'b0;
  assign alu_ready_in = (state_q == ST_WAIT);
`endif

  assign cmd_ready      = (state_q == ST_IDLE);
  assign alu_start      = (state_q == ST_ISSUE) && alu_ready_out;
  assign rsp_valid      = (state_q == ST_RESP);
  assign alu_op_a       = oper_q.op_a;
  assign alu_op_b       = oper_q.op_b;
  assign alu_op_code    = oper_q.op_code;
  assign alu_round_mode = oper_q.round_mode;
  assign alu_mode_fp    = oper_q.mode_fp;
  assign rsp_result     = rsp_result_q;
  assign rsp_flags      = rsp_flags_q;
  assign rsp_tag        = tag_q;
  assign sticky_flags   = sticky_q;

  always_comb begin
    sticky_d = sticky_q;
    if (capture) begin
      sticky_d = merge_flags(sticky_clr, sticky_q, alu_flags);
    end else if (sticky_clr) begin
      sticky_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      oper_q        <= '0;
      tag_q         <= '0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      sticky_q      <= '0;
`ifdef FPU_REQ_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      sticky_q <= sticky_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            oper_q  <= '{op_a: cmd_op_a, op_b: cmd_op_b, op_code: cmd_op_code,
                         round_mode: cmd_round_mode, mode_fp: cmd_mode_fp};
            tag_q   <= cmd_tag;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (alu_ready_out) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A result arriving on the expiry cycle still wins over the timeout.
          if (alu_valid_out) begin
            rsp_result_q  <= alu_result;
            rsp_flags_q   <= alu_flags;
`ifdef FPU_REQ_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
            state_q       <= ST_RESP;
          end
`ifdef FPU_REQ_TIMEOUT_EN
          else if (wd_expired) begin
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_timeout_q <= 1'b1;
            state_q       <= ST_FLUSH;
          end
`endif
        end
`ifdef FPU_REQ_TIMEOUT_EN
        ST_FLUSH: begin
          if (alu_ready_out) begin
            state_q <= ST_RESP;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_requester.sv
// Scoreboard bench for fpu_requester with a scripted ALU model.
// Timeout scenario runs only when FPU_REQ_TIMEOUT_EN is defined.
module tb_fpu_requester;
  import fpu_req_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_op_a = '0, cmd_op_b = '0;
  logic [2:0]  cmd_op_code = '0;
  logic        cmd_round_mode = 1'b0, cmd_mode_fp = 1'b0;
  logic [3:0]  cmd_tag = '0;
  logic        alu_start, alu_round_mode, alu_mode_fp, alu_ready_in;
  logic [31:0] alu_op_a, alu_op_b;
  logic [2:0]  alu_op_code;
  logic        alu_ready_out = 1'b0, alu_valid_out = 1'b0;
  logic [31:0] alu_result = '0;
  logic [4:0]  alu_flags = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags, sticky_flags;
  logic [3:0]  rsp_tag;
  logic        sticky_clr = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    logic [3:0]  tg;
    logic        to;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         start_cnt = 0;
  logic [4:0] sticky_exp = '0;

  fpu_requester #(.TAG_W(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_op_code(cmd_op_code),
    .cmd_round_mode(cmd_round_mode), .cmd_mode_fp(cmd_mode_fp), .cmd_tag(cmd_tag),
    .alu_start(alu_start), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_op_code(alu_op_code), .alu_round_mode(alu_round_mode), .alu_mode_fp(alu_mode_fp),
    .alu_ready_in(alu_ready_in), .alu_ready_out(alu_ready_out), .alu_valid_out(alu_valid_out),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) if (alu_start) start_cnt++;

  // Every accepted response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {28'd0, rsp_tag}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_result", rsp_result, e.res);
        check("rsp_flags", 32'(rsp_flags), 32'(e.fl));
        check("rsp_tag", 32'(rsp_tag), 32'(e.tg));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      end
    end
  end

  task automatic send_cmd(input logic [31:0] a, b, input logic [2:0] op,
                          input logic rm, fp, input logic [3:0] tg);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op_a = a; cmd_op_b = b; cmd_op_code = op;
    cmd_round_mode = rm; cmd_mode_fp = fp; cmd_tag = tg;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op_a = '1; cmd_op_b = '1; cmd_op_code = '1; cmd_tag = '1;
  endtask

  task automatic run_op(input logic [31:0] a, b, input logic [2:0] op, input logic rm, fp,
                        input logic [3:0] tg, input logic [31:0] res, input logic [4:0] fl,
                        input int rdy_dly, input int stall, input logic clr_cap);
    int starts0;
    starts0 = start_cnt;
    alu_ready_out = (rdy_dly == 0);
    sb.push_back('{res: res, fl: fl, tg: tg, to: 1'b0});
    send_cmd(a, b, op, rm, fp, tg);
    for (int i = 0; i < rdy_dly; i++) begin
      alu_valid_out = 1'b1; alu_result = 32'hDEAD_BEEF; alu_flags = '1;
      @(negedge clk);
      check("start_held", 32'(alu_start), 32'd0);
      check("opa_hold", alu_op_a, a);
      check("opb_hold", alu_op_b, b);
      @(posedge clk); #1;
    end
    alu_valid_out = 1'b0; alu_ready_out = 1'b1;
    @(negedge clk);
    check("alu_start", 32'(alu_start), 32'd1);
    check("alu_op_a", alu_op_a, a);
    check("alu_op_b", alu_op_b, b);
    check("alu_ctl", {27'd0, alu_op_code, alu_round_mode, alu_mode_fp}, {27'd0, op, rm, fp});
    @(posedge clk); #1;
    @(negedge clk);
    check("alu_ready_in", 32'(alu_ready_in), 32'd1);
    check("start_pulse", 32'(alu_start), 32'd0);
    check("opa_wait", alu_op_a, a);
    alu_valid_out = 1'b1; alu_result = res; alu_flags = fl; sticky_clr = clr_cap;
    @(posedge clk); #1;
    alu_valid_out = 1'b0; alu_result = '0; alu_flags = '0; sticky_clr = 1'b0;
    sticky_exp = clr_cap ? fl : (sticky_exp | fl);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("rsp_valid_stall", 32'(rsp_valid), 32'd1);
      check("cmd_ready_stall", 32'(cmd_ready), 32'd0);
      check("rsp_result_stable", rsp_result, res);
      check("rsp_tag_stable", 32'(rsp_tag), 32'(tg));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("sticky", 32'(sticky_flags), 32'(sticky_exp));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("cmd_ready_after", 32'(cmd_ready), 32'd1);
    check("rsp_valid_after", 32'(rsp_valid), 32'd0);
    check("start_once", 32'(start_cnt - starts0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_outs", {26'd0, alu_start, alu_ready_in, rsp_valid, rsp_timeout, 2'd0}, 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    check("rst_regs", alu_op_a | alu_op_b | rsp_result | 32'(rsp_tag), 32'd0);

    run_op(32'h4D30, 32'h4080, OP_ADD, 1'b0, 1'b0, 4'd3, 32'h4DC0, 5'd0, 0, 4, 1'b0);
    run_op(32'h0001_2345, 32'h0006_789A, OP_MUL, 1'b1, 1'b1, 4'd7, 32'h1234_5678,
           5'd1 << FLAG_I, 5, 0, 1'b0);
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    sticky_exp = '0;
    @(negedge clk);
    check("sticky_clr_idle", 32'(sticky_flags), 32'd0);
    run_op(32'h7BBF, 32'h7BBF, OP_ADD, 1'b1, 1'b0, 4'd5, 32'h7BFF,
           (5'd1 << FLAG_O) | (5'd1 << FLAG_X), 0, 0, 1'b0);
    run_op(32'h2E66, 32'h3266, OP_ADD, 1'b0, 1'b0, 4'd6, 32'h34CC, 5'd1 << FLAG_X, 2, 1, 1'b0);
    check("sticky_ox", 32'(sticky_flags), 32'(5'b10100));
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    sticky_exp = '0;
    @(negedge clk);
    check("sticky_cleared", 32'(sticky_flags), 32'd0);
    run_op(32'h3C00, 32'h0000, OP_DIV, 1'b0, 1'b0, 4'd1, 32'h7C00, 5'd1 << FLAG_Z, 0, 0, 1'b0);
    run_op(32'h0400, 32'h0400, OP_MUL, 1'b0, 1'b0, 4'd2, 32'h0000, 5'd1 << FLAG_U, 0, 0, 1'b1);

    // Stray result beat while idle must be ignored.
    alu_valid_out = 1'b1; alu_result = 32'hBAD0_BAD0; alu_flags = '1;
    @(posedge clk); #1;
    alu_valid_out = 1'b0; alu_flags = '0;
    @(negedge clk);
    check("idle_valid_ignored", 32'(rsp_valid), 32'd0);
    check("idle_sticky_kept", 32'(sticky_flags), 32'(sticky_exp));

    // Reset in WAIT aborts the command with no response.
    alu_ready_out = 1'b1;
    send_cmd(32'h1111, 32'h2222, OP_SUB, 1'b0, 1'b0, 4'd9);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_in_wait", 32'(alu_ready_in), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sticky_exp = '0;
    @(negedge clk);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_ready_in", 32'(alu_ready_in), 32'd0);
    check("abort_sticky", 32'(sticky_flags), 32'd0);
    rsp_ready = 1'b1;
    alu_valid_out = 1'b1; alu_result = 32'h0000_5555;
    repeat (2) @(posedge clk);
    #1 alu_valid_out = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;

`ifdef FPU_REQ_TIMEOUT_EN
    alu_ready_out = 1'b1;
    sb.push_back('{res: 32'd0, fl: 5'd0, tg: 4'd12, to: 1'b1});
    send_cmd(32'h4000, 32'h4000, OP_ADD, 1'b0, 1'b0, 4'd12);
    @(posedge clk); #1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check("to_no_rsp", 32'(rsp_valid), 32'd0);
      if (i == 9) begin
        alu_valid_out = 1'b1; alu_result = 32'h7777_7777; alu_flags = '1;
      end
      @(posedge clk); #1;
      alu_valid_out = 1'b0; alu_flags = '0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_sticky", 32'(sticky_flags), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("to_cmd_ready", 32'(cmd_ready), 32'd1);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
